md_issue_ctrl: RTL
==================

// Module: md_issue_ctrl
// PURPOSE
//  Sequencer for the shared multiply/divide unit in the execute stage. Captures a
//  mult/div issued from the D/X latch, pulses the unit's start control, freezes the
//  front of the pipeline (PC, F/D, D/X) until the result or a timeout, then presents
//  one writeback beat to the X/M latch. Exceptions are redirected to $r30 ($rstatus).
// PARAMETERS
//  TIMEOUT   40  max WAIT cycles before the op is declared failed (>=2)
//  MULT_CODE 4   $rstatus value written on mult exception
//  DIV_CODE  5   $rstatus value written on div exception / timeout of a div
// PORTS
//  clock        in   1   master clock, all state on rising edge
//  reset        in   1   asynchronous active-low reset (0 = reset)
//  issue_mult   in   1   D/X holds a mult this cycle
//  issue_div    in   1   D/X holds a div this cycle
//  flush        in   1   branch/jump squash; kills pending or in-flight op
//  op_a, op_b   in   32  operands ($rs, $rt) from D/X, bypassed
//  op_rd        in   5   destination register of issuing op
//  md_result    in   32  result from multiply/divide unit
//  md_exception in   1   unit exception (overflow / divide-by-zero), valid with md_ready
//  md_ready     in   1   unit result valid
//  md_op_a/b    out  32  held operands driven to the unit
//  ctrl_MULT    out  1   one-cycle mult start pulse
//  ctrl_DIV     out  1   one-cycle div start pulse
//  stall        out  1   freeze PC/F/D/D/X, insert nop into X/M
//  busy         out  1   state != IDLE
//  wb_valid     out  1   one-cycle writeback beat into X/M
//  wb_we        out  1   wb_valid & (wb_rd != 0)
//  wb_rd        out  5   op_rd, or 30 on exception
//  wb_data      out  32  md_result, or MULT_CODE/DIV_CODE on exception
//  timeout_err  out  1   sticky; set on timeout, cleared only by reset
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, counter 0, every output 0 incl. md_op_a/b.
//  States IDLE -> START -> WAIT -> DONE -> IDLE.
//  IDLE: issue = (issue_mult|issue_div) & ~flush. On issue: latch op_a/op_b/op_rd and
//   op type (mult wins if both asserted), -> START. stall is combinational: high in
//   the issue cycle itself so D/X holds the instruction.
//  START: registered ctrl_MULT or ctrl_DIV high this cycle only; stall=1; md_ready
//   ignored; counter cleared; -> WAIT.
//  WAIT: stall=1; counter += 1 per cycle. md_ready=1 -> capture result/exception,
//   -> DONE. Counter == TIMEOUT with no ready -> DONE as exception, set timeout_err.
//   Ready on the same cycle as timeout: ready wins, no timeout_err.
//  DONE: stall=0, wb_valid=1 for exactly one cycle, -> IDLE. issue inputs ignored in
//   DONE (D/X still holds the same op). Exception: wb_rd=30, wb_data=code by op type.
//  Latency: issue at cycle 0, start pulse cycle 1, ready at cycle N (N>=2) -> wb_valid
//   at N+1; stall high cycles 0..N. Back-to-back ops: next issue accepted in IDLE
//   the cycle after DONE.
//  flush in START/WAIT: -> IDLE next edge, no wb_valid, stall low from next cycle;
//   late md_ready in IDLE ignored. flush in DONE: wb_valid suppressed.
//  md_op_a/b hold captured values until next capture; unchanged by flush.
//  Counter width $clog2(TIMEOUT+1); no wrap (saturates via timeout exit).
// TESTING
//  mult 3*7, rd=5, ready after 17 WAIT cycles -> one ctrl_MULT pulse, stall 19 cycles,
//   wb_valid once with wb_rd=5, wb_data=21, wb_we=1.
//  div 10/0, unit md_exception=1 -> wb_rd=30, wb_data=5; mult overflow -> wb_data=4.
//  mult with rd=0 -> wb_valid=1, wb_we=0; issue_mult held through DONE -> no re-issue.
//  no md_ready -> after TIMEOUT=40 WAIT cycles wb_rd=30, timeout_err=1 and stays set.
//  flush at WAIT cycle 5 -> no wb_valid, stall low next cycle; reset=0 mid-WAIT ->
//   all outputs 0 immediately, IDLE after release.
//  issue_mult & issue_div together -> ctrl_MULT only; issue with flush -> no capture.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// Bundle between the D/X latch, the multiply/divide unit, the X/M latch and the
// mult/div issue sequencer. The sequencer uses the slave side.
interface md_issue_ctrl_if;
   logic        issue_mult;
   logic        issue_div;
   logic        flush;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  op_rd;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_ready;
   logic [31:0] md_op_a;
   logic [31:0] md_op_b;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic        stall;
   logic        busy;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        timeout_err;

   modport master (
      output issue_mult, issue_div, flush, op_a, op_b, op_rd,
             md_result, md_exception, md_ready,
      input  md_op_a, md_op_b, ctrl_MULT, ctrl_DIV, stall, busy,
             wb_valid, wb_we, wb_rd, wb_data, timeout_err
   );

   modport slave (
      input  issue_mult, issue_div, flush, op_a, op_b, op_rd,
             md_result, md_exception, md_ready,
      output md_op_a, md_op_b, ctrl_MULT, ctrl_DIV, stall, busy,
             wb_valid, wb_we, wb_rd, wb_data, timeout_err
   );
endinterface

// File: rtl/md_issue_ctrl.sv
// Issue sequencer for the shared multiply/divide unit: captures the op, pulses start,
// stalls the front end until result or timeout, then emits one writeback beat.
module md_issue_ctrl #(
   parameter int TIMEOUT   = 40,
   parameter int MULT_CODE = 4,
   parameter int DIV_CODE  = 5
) (
   input  logic           clock,
   input  logic           reset,
   md_issue_ctrl_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_is_mult;
   logic          r_ctrl_mult;
   logic          r_ctrl_div;
   logic          r_timeout_err;
   logic [31:0]   r_op_a;
   logic [31:0]   r_op_b;
   logic [4:0]    r_op_rd;
   logic [4:0]    r_wb_rd;
   logic [31:0]   r_wb_data;
   logic          w_issue;
   logic          w_accept;
   logic          w_timeout;
   logic          w_wb_valid;

   // $rstatus code reported for a failed op of the given type
   function automatic logic [31:0] exc_code(input logic is_mult);
      return is_mult ? 32'(MULT_CODE) : 32'(DIV_CODE);
   endfunction

   assign w_issue   = (bus.issue_mult | bus.issue_div) & ~bus.flush;
   assign w_accept  = (r_state == ST_IDLE) & w_issue;
   assign w_timeout = (r_cnt == TIMEOUT_CNT) & ~bus.md_ready;

   // Next-state decode; flush abandons the op from START or WAIT
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_issue) w_state_nxt = ST_START;
            else         w_state_nxt = ST_IDLE;
         end
         ST_START: begin
            if (bus.flush) w_state_nxt = ST_IDLE;
            else           w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (bus.flush)                       w_state_nxt = ST_IDLE;
            else if (bus.md_ready || w_timeout)  w_state_nxt = ST_DONE;
            else                                 w_state_nxt = ST_WAIT;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // State, operand capture, start pulses, wait counter and writeback capture
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_is_mult     <= 1'b0;
         r_ctrl_mult   <= 1'b0;
         r_ctrl_div    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_op_a        <= 32'd0;
         r_op_b        <= 32'd0;
         r_op_rd       <= 5'd0;
         r_wb_rd       <= 5'd0;
         r_wb_data     <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_ctrl_mult <= w_accept & bus.issue_mult;
         r_ctrl_div  <= w_accept & ~bus.issue_mult;
         if (w_accept) begin
            r_op_a    <= bus.op_a;
            r_op_b    <= bus.op_b;
            r_op_rd   <= bus.op_rd;
            r_is_mult <= bus.issue_mult;
         end
         if (r_state == ST_START) begin
            r_cnt <= '0;
         end else if ((r_state == ST_WAIT) && (r_cnt != TIMEOUT_CNT)) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         // A ready on the timeout cycle still counts as a normal completion
         if ((r_state == ST_WAIT) && !bus.flush) begin
            if (bus.md_ready) begin
               r_wb_rd   <= bus.md_exception ? 5'd30 : r_op_rd;
               r_wb_data <= bus.md_exception ? exc_code(r_is_mult) : bus.md_result;
            end else if (w_timeout) begin
               r_wb_rd       <= 5'd30;
               r_wb_data     <= exc_code(r_is_mult);
               r_timeout_err <= 1'b1;
            end
         end
      end
   end

   assign w_wb_valid = (r_state == ST_DONE) & ~bus.flush;

   // Issue-cycle stall is combinational so D/X holds the op being captured
   assign bus.stall       = reset & ((r_state == ST_START) | (r_state == ST_WAIT) | w_accept);
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.ctrl_MULT   = r_ctrl_mult;
   assign bus.ctrl_DIV    = r_ctrl_div;
   assign bus.md_op_a     = r_op_a;
   assign bus.md_op_b     = r_op_b;
   assign bus.wb_valid    = w_wb_valid;
   assign bus.wb_we       = w_wb_valid & (r_wb_rd != 5'd0);
   assign bus.wb_rd       = r_wb_rd;
   assign bus.wb_data     = r_wb_data;
   assign bus.timeout_err = r_timeout_err;
endmodule
